// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - Synchronous single-clock FIFO with threshold flags, occupancy count and sticky errors
//
// Purpose: buffers words between producer and consumer stages sharing one
// clock. Offers programmable almost-full/almost-empty thresholds, an
// occupancy count, standard (registered) or first-word-fall-through read
// mode, and sticky overflow/underflow flags cleared by i_clr_err.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_cs           chip select; gates i_wr_en and i_rd_en
//   i_wr_en        write request
//   i_rd_en        read request
//   i_clr_err      synchronous clear of o_overflow / o_underflow
//   i_datain       write data
//   o_dataout      read data
//   o_empty        count == 0
//   o_full         count == FIFO_DEPTH
//   o_almost_empty count <= AEMPTY_TH
//   o_almost_full  count >= AFULL_TH
//   o_count        current occupancy
//   o_overflow     sticky: a write was rejected
//   o_underflow    sticky: a read was rejected
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cs,
  input  logic                          i_wr_en,
  input  logic                          i_rd_en,
  input  logic                          i_clr_err,
  input  logic [DATA_WIDTH-1:0]         i_datain,
  output logic [DATA_WIDTH-1:0]         o_dataout,
  output logic                          o_empty,
  output logic                          o_full,
  output logic                          o_almost_empty,
  output logic                          o_almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  // All flags decode straight from the registered count.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = i_cs & i_wr_en & ~w_full;
  assign w_rd_acc = i_cs & i_rd_en & ~w_empty;
  assign w_wr_rej = i_cs & i_wr_en & w_full;
  assign w_rd_rej = i_cs & i_rd_en & w_empty;

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_datain;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error takes priority over a coincident clear so it is never lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_rej)       r_overflow <= 1'b1;
      else if (i_clr_err) r_overflow <= 1'b0;
      if (w_rd_rej)       r_underflow <= 1'b1;
      else if (i_clr_err) r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero when empty.
      assign o_dataout = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dataout;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_dataout <= '0;
        end else if (w_rd_acc) begin
          r_dataout <= r_mem[r_rd_ptr];
        end
      end
      assign o_dataout = r_dataout;
    end
  endgenerate

  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_empty = (r_count <= CW'(AEMPTY_TH));
  assign o_almost_full  = (r_count >= CW'(AFULL_TH));
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - Scoreboard bench for fifo_sync_flags in standard and FWFT read modes
module tb_fifo_sync_flags;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] datain = '0;

  logic [DW-1:0] d0_dout, d1_dout;
  logic          d0_empty, d0_full, d0_ae, d0_af, d0_ovf, d0_unf;
  logic          d1_empty, d1_full, d1_ae, d1_af, d1_ovf, d1_unf;
  logic [CW-1:0] d0_count, d1_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_wr_en(wr_en), .i_rd_en(rd_en), .i_clr_err(clr_err),
    .i_datain(datain), .o_dataout(d0_dout), .o_empty(d0_empty), .o_full(d0_full),
    .o_almost_empty(d0_ae), .o_almost_full(d0_af), .o_count(d0_count),
    .o_overflow(d0_ovf), .o_underflow(d0_unf)
  );

  fifo_sync_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_wr_en(wr_en), .i_rd_en(rd_en), .i_clr_err(clr_err),
    .i_datain(datain), .o_dataout(d1_dout), .o_empty(d1_empty), .o_full(d1_full),
    .o_almost_empty(d1_ae), .o_almost_full(d1_af), .o_count(d1_count),
    .o_overflow(d1_ovf), .o_underflow(d1_unf)
  );

  // Reference model: contents as a plain queue, last popped word, sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;
  bit            m_ovf, m_unf;

  typedef struct {
    int            cnt;
    bit            ovf;
    bit            unf;
    logic [DW-1:0] d_std;
    logic [DW-1:0] d_fwft;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t snap();
    exp_t e;
    e.cnt    = mq.size();
    e.ovf    = m_ovf;
    e.unf    = m_unf;
    e.d_std  = m_last;
    e.d_fwft = (mq.size() != 0) ? mq[0] : '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising clock or reset edge, compare against the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("std_count",  DW'(d0_count), DW'(e.cnt));
        chk("std_dout",   d0_dout, e.d_std);
        chk("std_empty",  DW'(d0_empty), DW'(e.cnt == 0));
        chk("std_full",   DW'(d0_full),  DW'(e.cnt == DEPTH));
        chk("std_aempty", DW'(d0_ae),    DW'(e.cnt <= AET));
        chk("std_afull",  DW'(d0_af),    DW'(e.cnt >= AFT));
        chk("std_ovf",    DW'(d0_ovf),   DW'(e.ovf));
        chk("std_unf",    DW'(d0_unf),   DW'(e.unf));
        chk("fwft_count", DW'(d1_count), DW'(e.cnt));
        chk("fwft_dout",  d1_dout, e.d_fwft);
        chk("fwft_empty", DW'(d1_empty), DW'(e.cnt == 0));
        chk("fwft_full",  DW'(d1_full),  DW'(e.cnt == DEPTH));
        chk("fwft_ovf",   DW'(d1_ovf),   DW'(e.ovf));
        chk("fwft_unf",   DW'(d1_unf),   DW'(e.unf));
      end
    end
  end

  task automatic step(input bit c, input bit w, input bit r, input bit clr, input logic [DW-1:0] din);
    bit was_full, was_empty;
    @(negedge clk);
    cs = c; wr_en = w; rd_en = r; clr_err = clr; datain = din;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (c && r && !was_empty) m_last = mq.pop_front();
    if (c && w && !was_full)  mq.push_back(din);
    if (c && w && was_full)   m_ovf = 1'b1;
    else if (clr)             m_ovf = 1'b0;
    if (c && r && was_empty)  m_unf = 1'b1;
    else if (clr)             m_unf = 1'b0;
    exp_q.push_back(snap());
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
  endtask

  // Reset lands between clock edges so its effect is seen with no edge.
  task automatic async_reset();
    @(negedge clk);
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #2;
    mq.delete();
    m_last = '0; m_ovf = 1'b0; m_unf = 1'b0;
    exp_q.push_back(snap());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    m_last = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    exp_q.push_back(snap());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Basic ordering with registered read.
    wr(34); wr(100); wr(1);
    rd(); rd(); rd();

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 8; i++) wr(DW'(1) << i);
    wr(256);
    for (int i = 0; i < 8; i++) rd();
    // Refill across the pointer wrap.
    for (int i = 0; i < 8; i++) wr($urandom);
    for (int i = 0; i < 8; i++) rd();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Steady state at count 4 with simultaneous read and write.
    for (int i = 0; i < 4; i++) wr($urandom);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    // Simultaneous at full.
    for (int i = 0; i < 4; i++) wr($urandom);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 7; i++) rd();
    // Simultaneous at empty.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234);
    rd();
    // Clear coinciding with read-on-empty keeps underflow; plain clear drops both.
    step(1'b1, 1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Head word visible without a read in FWFT mode.
    wr(32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rd();

    // cs=0 blocks requests.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Async reset mid-burst.
    for (int i = 0; i < 5; i++) wr($urandom);
    async_reset();

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0), $urandom);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    @(negedge clk);
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's `fifosyn` buffer.
- Adds the following over `fifosyn`:
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - sticky overflow/underflow error flags.
- Sits between producer and consumer datapath stages in the same clock domain.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- FIFO_DEPTH, 8: number of entries; power of two, at least 2.
- AFULL_TH, 6: almost_full asserts when count >= AFULL_TH (1..FIFO_DEPTH).
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH (0..FIFO_DEPTH-1).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  chip select; wr_en and rd_en are ignored when cs=0.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- clr_err  input  1  synchronous clear of overflow and underflow.
- datain  input  DATA_WIDTH  write data.
- dataout  output  DATA_WIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == FIFO_DEPTH.
- almost_empty  output  1  count <= AEMPTY_TH.
- almost_full  output  1  count >= AFULL_TH.
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; a write was rejected.
- underflow  output  1  sticky; a read was rejected.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-transfer):
  - write/read pointers, count, dataout, overflow and underflow all go to 0; empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are don't-care.
  - First accepted operation is on the first rising edge with rst=0.
- Acceptance, evaluated on state before the edge:
  - wr_acc = cs & wr_en & !full.
  - rd_acc = cs & rd_en & !empty.
- Write: on wr_acc, mem[wr_ptr] <= datain; wr_ptr increments modulo FIFO_DEPTH (natural wrap; pointers are $clog2(FIFO_DEPTH) bits).
- Read, FWFT=0: on rd_acc, dataout <= mem[rd_ptr] at that edge (1-cycle latency); rd_ptr increments. dataout holds its last value otherwise.
- Read, FWFT=1:
  - dataout = mem[rd_ptr] whenever !empty, so the head word is visible the cycle after it is written.
  - rd_acc pops the head and dataout shows the next word.
  - dataout = 0 while empty.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Flags: empty, full, almost_* are decoded from the registered count; no extra latency beyond count.
- Simultaneous read and write:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected (overflow set).
  - Empty: write accepted, read rejected (underflow set).
- Error flags:
  - overflow <= 1 on cs & wr_en & full.
  - underflow <= 1 on cs & rd_en & empty.
  - clr_err=1 clears both at the edge. If clr_err and a new error coincide, the error wins (flag stays 1).
  - Rejected operations never move pointers, count or dataout.
- cs=0: no state change except clr_err handling.

Test Plan:
- Reset then FWFT=0: write 34, 100, 1; read three times -> dataout 34, 100, 1, each one cycle after its read edge; count 3->0; empty=1 at end.
- Fill/drain with wrap: write 2**i for i=0..7, then a 9th write of 256 -> full=1, count=8, overflow=1; read 8 -> 1, 2, ..., 128; 256 never appears. Refill 8 words -> correct order across the pointer wrap.
- Thresholds (AFULL_TH=6, AEMPTY_TH=2):
  - almost_empty=1 for count 0..2, 0 at count 3.
  - almost_full goes 0->1 as count goes 5->6, and drops on the read taking count 6->5.
- Simultaneous operations:
  - count=4 with wr+rd each cycle for 10 cycles -> count stays 4, data order preserved.
  - Full with wr+rd -> count 8->7, overflow=1.
  - Empty with wr+rd -> count 0->1, underflow=1.
- FWFT=1: write 0xA5 -> dataout=0xA5 the cycle after the write with no read issued; read -> empty=1, dataout=0.
- Async reset mid-burst after 5 writes -> outputs cleared immediately without a clock edge. clr_err pulse clears sticky flags; clr_err coincident with a read-on-empty leaves underflow=1.
